// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared read-mode constants and sizing helper for the flag FIFO
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Fill level needs one more bit than the address so it can hold DEPTH itself.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port register array, synchronous write, asynchronous read
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with fill level, threshold flags, flush and error status
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    localparam int PTR_WIDTH    = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = FIFO_MODE_STD
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 wr_error_o,
    output logic                 rd_error_o,
    output logic                 ovf_sticky_o,
    output logic                 unf_sticky_o,
    input  logic                 clr_err_i
);

    localparam int CNT_W = fifo_cnt_width(DEPTH);

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [CNT_W-1:0]   count_nxt;
    logic               wr_acc;
    logic               rd_acc;
    logic               wr_err_nxt;
    logic               rd_err_nxt;
    logic               mem_we;
    logic [WIDTH-1:0]   mem_rdata;

    // Acceptance uses the registered flags, so a full FIFO never passes a write through a same-cycle read.
    always_comb begin
        wr_acc     = wr_en_i & ~full_o;
        rd_acc     = rd_en_i & ~empty_o;
        wr_err_nxt = wr_en_i & full_o & ~flush_i;
        rd_err_nxt = rd_en_i & empty_o & ~flush_i;
        mem_we     = wr_acc & ~flush_i & ~rst_i;
        count_nxt  = count_o;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_o + CNT_W'(1);
            2'b01:   count_nxt = count_o - CNT_W'(1);
            default: count_nxt = count_o;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            wr_error_o     <= 1'b0;
            rd_error_o     <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr + {{PTR_WIDTH{1'b0}}, wr_acc};
            rd_ptr         <= rd_ptr + {{PTR_WIDTH{1'b0}}, rd_acc};
            count_o        <= count_nxt;
            full_o         <= (int'(count_nxt) == DEPTH);
            empty_o        <= (count_nxt == '0);
            almost_full_o  <= (int'(count_nxt) >= AFULL_THRESH);
            almost_empty_o <= (int'(count_nxt) <= AEMPTY_THRESH);
            wr_error_o     <= wr_err_nxt;
            rd_error_o     <= rd_err_nxt;
        end
    end

    // Sticky bits survive flush; a new error outranks a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_sticky_o <= 1'b0;
            unf_sticky_o <= 1'b0;
        end else begin
            if (wr_err_nxt) begin
                ovf_sticky_o <= 1'b1;
            end else if (clr_err_i) begin
                ovf_sticky_o <= 1'b0;
            end
            if (rd_err_nxt) begin
                unf_sticky_o <= 1'b1;
            end else if (clr_err_i) begin
                unf_sticky_o <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr[PTR_WIDTH-1:0]),
        .wdata_i (wdata_i),
        .raddr_i (rd_ptr[PTR_WIDTH-1:0]),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign rdata_o = mem_rdata;
        end else begin : g_std
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rdata_o <= '0;
                end else if (rd_acc && !flush_i) begin
                    rdata_o <= mem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags in both read modes
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] rdata_a, rdata_b;
    logic       full_a, empty_a, af_a, ae_a, wr_err_a, rd_err_a, ovf_a, unf_a;
    logic       full_b, empty_b, af_b, ae_b, wr_err_b, rd_err_b, ovf_b, unf_b;
    logic [4:0] count_a, count_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)
    ) dut_std (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .rdata_o(rdata_a), .full_o(full_a), .empty_o(empty_a),
        .almost_full_o(af_a), .almost_empty_o(ae_a), .count_o(count_a),
        .wr_error_o(wr_err_a), .rd_error_o(rd_err_a), .ovf_sticky_o(ovf_a),
        .unf_sticky_o(unf_a), .clr_err_i(clr_err)
    );

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)
    ) dut_fwft (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .rdata_o(rdata_b), .full_o(full_b), .empty_o(empty_b),
        .almost_full_o(af_b), .almost_empty_o(ae_b), .count_o(count_b),
        .wr_error_o(wr_err_b), .rd_error_o(rd_err_b), .ovf_sticky_o(ovf_b),
        .unf_sticky_o(unf_b), .clr_err_i(clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count_a), 32'd0);
        check({tag, "_empty"}, 32'(empty_a), 32'd1);
        check({tag, "_full"}, 32'(full_a), 32'd0);
        check({tag, "_ae"}, 32'(ae_a), 32'd1);
        check({tag, "_af"}, 32'(af_a), 32'd0);
        check({tag, "_rdata"}, 32'(rdata_a), 32'd0);
        check({tag, "_errs"}, {28'd0, wr_err_a, rd_err_a, ovf_a, unf_a}, 32'd0);
        check({tag, "_fwft_empty"}, 32'(empty_b), 32'd1);
    endtask

    initial begin
        // Reset
        cycle();
        rst = 1'b0;
        check_reset_state("reset");

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wdata = 8'(i);
            cycle();
            check("fill_count", 32'(count_a), 32'(i + 1));
            check("fill_af", 32'(af_a), 32'((i + 1) >= 14));
            check("fill_ae", 32'(ae_a), 32'((i + 1) <= 2));
        end
        check("fill_full", 32'(full_a), 32'd1);
        check("fill_empty", 32'(empty_a), 32'd0);

        // Overflow: one more write of 0xAA
        wdata = 8'hAA;
        cycle();
        check("ovf_pulse", 32'(wr_err_a), 32'd1);
        check("ovf_sticky", 32'(ovf_a), 32'd1);
        check("ovf_count", 32'(count_a), 32'd16);
        wr_en = 1'b0;
        cycle();
        check("ovf_pulse_end", 32'(wr_err_a), 32'd0);
        check("ovf_sticky_hold", 32'(ovf_a), 32'd1);
        // Set beats clear in the same cycle
        wr_en = 1'b1;
        clr_err = 1'b1;
        cycle();
        check("ovf_set_prio", {30'd0, wr_err_a, ovf_a}, 32'd3);
        wr_en = 1'b0;
        cycle();
        check("ovf_cleared", {30'd0, wr_err_a, ovf_a}, 32'd0);
        clr_err = 1'b0;

        // Drain: order 0x00..0x0F, no 0xAA; FWFT shows the head before each pop
        for (int i = 0; i < 16; i++) begin
            check("fwft_head", 32'(rdata_b), 32'(i));
            rd_en = 1'b1;
            cycle();
            check("drain_data", 32'(rdata_a), 32'(i));
            check("drain_count", 32'(count_a), 32'(15 - i));
        end
        check("drain_empty", 32'(empty_a), 32'd1);

        // Underflow
        cycle();
        check("unf_pulse", 32'(rd_err_a), 32'd1);
        check("unf_sticky", 32'(unf_a), 32'd1);
        check("unf_rdata_hold", 32'(rdata_a), 32'h0F);
        check("unf_count", 32'(count_a), 32'd0);
        rd_en = 1'b0;
        cycle();
        check("unf_pulse_end", {30'd0, rd_err_a, unf_a}, 32'd1);

        // Registered read latency with 0x5C
        wr_en = 1'b1;
        wdata = 8'h5C;
        cycle();
        wr_en = 1'b0;
        check("lat_empty_after_wr", 32'(empty_a), 32'd0);
        check("lat_rdata_before_rd", 32'(rdata_a), 32'h0F);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("lat_rdata", 32'(rdata_a), 32'h5C);
        check("lat_empty", 32'(empty_a), 32'd1);

        // FWFT: 0x3E visible one edge after the write, before any pop
        wr_en = 1'b1;
        wdata = 8'h3E;
        cycle();
        wr_en = 1'b0;
        check("fwft_data", 32'(rdata_b), 32'h3E);
        check("fwft_not_empty", 32'(empty_b), 32'd0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("fwft_pop_empty", 32'(empty_b), 32'd1);
        check("fwft_pop_count", 32'(count_b), 32'd0);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("unf_cleared", 32'(unf_a), 32'd0);

        // Simultaneous read/write at count 8 with wrap-around
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1;
            wdata = 8'h40 + 8'(k);
            cycle();
        end
        check("sim_pre_count", 32'(count_a), 32'd8);
        rd_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wdata = 8'h48 + 8'(k);
            cycle();
            check("sim_count", 32'(count_a), 32'd8);
            check("sim_data", 32'(rdata_a), 32'(8'h40 + 8'(k)));
            check("sim_errs", {30'd0, wr_err_a, rd_err_a}, 32'd0);
        end
        rd_en = 1'b0;

        // Flush at count 9 together with a write
        wdata = 8'h70;
        cycle();
        check("flush_pre_count", 32'(count_a), 32'd9);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wr_en = 1'b0;
        check("flush_count", 32'(count_a), 32'd0);
        check("flush_flags", {28'd0, empty_a, ae_a, full_a, af_a}, 32'b1100);
        check("flush_no_err", 32'(wr_err_a), 32'd0);
        check("flush_rdata_hold", 32'(rdata_a), 32'h67);
        // Flush with a read on empty: still no error
        flush = 1'b1;
        rd_en = 1'b1;
        cycle();
        flush = 1'b0;
        rd_en = 1'b0;
        check("flush_no_rd_err", {30'd0, rd_err_a, unf_a}, 32'd0);

        // Refill to 5, then reset
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1;
            wdata = 8'h90 + 8'(k);
            cycle();
        end
        wr_en = 1'b0;
        check("refill_count", 32'(count_a), 32'd5);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("refill_rd", 32'(rdata_a), 32'h90);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_state("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
